// File: rtl/pipeline_hazard_ctrl.sv
// Front-end stall/kill/redirect controller: structural-hazard stalls, mispredict
// recovery sequencing (kill + redirect, then a rename-restore window) and perf counters.
module pipeline_hazard_ctrl #(
    parameter int ADDR_LEN     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                rrf_allocatable_i,
    input  logic                rob_full_i,
    input  logic [1:0]          req_alu_num_i,
    input  logic [1:0]          req_mem_num_i,
    input  logic                alu_rs_full_i,
    input  logic                mem_rs_full_i,
    input  logic                branch_valid_i,
    input  logic                branch_mispredict_i,
    input  logic [ADDR_LEN-1:0] branch_target_i,
    output logic                stall_IF_o,
    output logic                stall_ID_o,
    output logic                stall_DP_o,
    output logic                kill_IF_o,
    output logic                kill_ID_o,
    output logic                kill_DP_o,
    output logic                redirect_valid_o,
    output logic [ADDR_LEN-1:0] redirect_pc_o,
    output logic                recover_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int DC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    state_t              state_q, state_d;
    logic [DC_W-1:0]     down_q;
    logic [ADDR_LEN-1:0] target_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                dp_hazard;
    logic                accept;

    assign dp_hazard = !rrf_allocatable_i
                     | rob_full_i
                     | ((req_alu_num_i != 2'd0) & alu_rs_full_i)
                     | ((req_mem_num_i != 2'd0) & mem_rs_full_i);

    // Mispredicts seen outside RUN come from already-killed instructions.
    assign accept = (state_q == RUN) & branch_valid_i & branch_mispredict_i;

    // State register, down-counter, latched target and saturating counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            down_q      <= '0;
            target_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            if (state_q == FLUSH)
                down_q <= DC_W'(FLUSH_CYCLES);
            else if (state_q == RECOVER)
                down_q <= down_q - DC_W'(1);
            if (accept)
                target_q <= branch_target_i;
            if (stall_DP_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (accept && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        state_d = state_q;
        unique case (state_q)
            RUN:     if (accept) state_d = FLUSH;
            FLUSH:   state_d = (FLUSH_CYCLES == 0) ? RUN : RECOVER;
            RECOVER: if (down_q <= DC_W'(1)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Kills, redirect and recover decode only from the state flop, never from branch_* inputs.
    always_comb begin
        stall_DP_o       = 1'b0;
        kill_DP_o        = 1'b0;
        redirect_valid_o = 1'b0;
        recover_o        = 1'b0;
        unique case (state_q)
            RUN:     stall_DP_o = dp_hazard;
            FLUSH: begin
                kill_DP_o        = 1'b1;
                redirect_valid_o = 1'b1;
                recover_o        = 1'b1;
            end
            RECOVER: begin
                stall_DP_o = 1'b1;
                recover_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall_IF_o    = stall_DP_o;
    assign stall_ID_o    = stall_DP_o;
    assign kill_IF_o     = kill_DP_o;
    assign kill_ID_o     = kill_DP_o;
    assign redirect_pc_o = target_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: three configurations driven in lockstep
// and compared each cycle against a window-based behavioural model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_i, rrf_allocatable_i, rob_full_i;
    logic [1:0]  req_alu_num_i, req_mem_num_i;
    logic        alu_rs_full_i, mem_rs_full_i;
    logic        branch_valid_i, branch_mispredict_i;
    logic [31:0] branch_target_i;

    logic [2:0]  st_if, st_id, st_dp, k_if, k_id, k_dp, rv, rc;
    logic [31:0] pc [3];
    logic [31:0] scnt0, fcnt0, scnt1, fcnt1;
    logic [3:0]  scnt2, fcnt2;

    int vectors = 0;
    int miscompares = 0;

    // Model: per instance, cycles left in the flush+recover window after an accepted mispredict.
    int          fc_m [3] = '{2, 0, 3};
    longint      cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    int          rem  [3];
    logic [31:0] tgt_m [3];
    longint      scnt_m [3], fcnt_m [3];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.ADDR_LEN(32), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .rrf_allocatable_i(rrf_allocatable_i),
        .rob_full_i(rob_full_i), .req_alu_num_i(req_alu_num_i), .req_mem_num_i(req_mem_num_i),
        .alu_rs_full_i(alu_rs_full_i), .mem_rs_full_i(mem_rs_full_i),
        .branch_valid_i(branch_valid_i), .branch_mispredict_i(branch_mispredict_i),
        .branch_target_i(branch_target_i),
        .stall_IF_o(st_if[0]), .stall_ID_o(st_id[0]), .stall_DP_o(st_dp[0]),
        .kill_IF_o(k_if[0]), .kill_ID_o(k_id[0]), .kill_DP_o(k_dp[0]),
        .redirect_valid_o(rv[0]), .redirect_pc_o(pc[0]), .recover_o(rc[0]),
        .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

    pipeline_hazard_ctrl #(.ADDR_LEN(32), .FLUSH_CYCLES(0), .CNT_WIDTH(32)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .rrf_allocatable_i(rrf_allocatable_i),
        .rob_full_i(rob_full_i), .req_alu_num_i(req_alu_num_i), .req_mem_num_i(req_mem_num_i),
        .alu_rs_full_i(alu_rs_full_i), .mem_rs_full_i(mem_rs_full_i),
        .branch_valid_i(branch_valid_i), .branch_mispredict_i(branch_mispredict_i),
        .branch_target_i(branch_target_i),
        .stall_IF_o(st_if[1]), .stall_ID_o(st_id[1]), .stall_DP_o(st_dp[1]),
        .kill_IF_o(k_if[1]), .kill_ID_o(k_id[1]), .kill_DP_o(k_dp[1]),
        .redirect_valid_o(rv[1]), .redirect_pc_o(pc[1]), .recover_o(rc[1]),
        .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

    pipeline_hazard_ctrl #(.ADDR_LEN(32), .FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .rrf_allocatable_i(rrf_allocatable_i),
        .rob_full_i(rob_full_i), .req_alu_num_i(req_alu_num_i), .req_mem_num_i(req_mem_num_i),
        .alu_rs_full_i(alu_rs_full_i), .mem_rs_full_i(mem_rs_full_i),
        .branch_valid_i(branch_valid_i), .branch_mispredict_i(branch_mispredict_i),
        .branch_target_i(branch_target_i),
        .stall_IF_o(st_if[2]), .stall_ID_o(st_id[2]), .stall_DP_o(st_dp[2]),
        .kill_IF_o(k_if[2]), .kill_ID_o(k_id[2]), .kill_DP_o(k_dp[2]),
        .redirect_valid_o(rv[2]), .redirect_pc_o(pc[2]), .recover_o(rc[2]),
        .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] got_flags(input int i);
        return {st_if[i], st_id[i], st_dp[i], k_if[i], k_id[i], k_dp[i], rv[i], rc[i]};
    endfunction

    function automatic logic [63:0] got_scnt(input int i);
        case (i)
            0: return {32'd0, scnt0};
            1: return {32'd0, scnt1};
            default: return {60'd0, scnt2};
        endcase
    endfunction

    function automatic logic [63:0] got_fcnt(input int i);
        case (i)
            0: return {32'd0, fcnt0};
            1: return {32'd0, fcnt1};
            default: return {60'd0, fcnt2};
        endcase
    endfunction

    // One clock: drive inputs mid-low phase, check all instances, then advance the model.
    task automatic cycle(input logic rst, input logic rrf, input logic rob,
                         input logic [1:0] ra, input logic [1:0] rm,
                         input logic af, input logic mf,
                         input logic bv, input logic bm, input logic [31:0] tg);
        logic       haz;
        logic [7:0] exp_f;
        @(negedge clk);
        reset_i = rst; rrf_allocatable_i = rrf; rob_full_i = rob;
        req_alu_num_i = ra; req_mem_num_i = rm; alu_rs_full_i = af; mem_rs_full_i = mf;
        branch_valid_i = bv; branch_mispredict_i = bm; branch_target_i = tg;
        #1;
        haz = !rrf || rob || (ra != 0 && af) || (rm != 0 && mf);
        for (int i = 0; i < 3; i++) begin
            if (rem[i] == 0)              exp_f = {haz, haz, haz, 5'b00000};
            else if (rem[i] == 1 + fc_m[i]) exp_f = 8'b000_111_1_1;
            else                          exp_f = 8'b111_000_0_1;
            check($sformatf("flags%0d", i), {56'd0, got_flags(i)}, {56'd0, exp_f});
            check($sformatf("redirect_pc%0d", i), {32'd0, pc[i]}, {32'd0, tgt_m[i]});
            check($sformatf("stall_cnt%0d", i), got_scnt(i), scnt_m[i]);
            check($sformatf("flush_cnt%0d", i), got_fcnt(i), fcnt_m[i]);
            if (rst) begin
                rem[i] = 0; tgt_m[i] = '0; scnt_m[i] = 0; fcnt_m[i] = 0;
            end else begin
                if (exp_f[5] && scnt_m[i] < cmax[i]) scnt_m[i]++;
                if (rem[i] == 0 && bv && bm) begin
                    rem[i] = 1 + fc_m[i];
                    tgt_m[i] = tg;
                    if (fcnt_m[i] < cmax[i]) fcnt_m[i]++;
                end else if (rem[i] > 0) begin
                    rem[i]--;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        reset_i = 1; rrf_allocatable_i = 1; rob_full_i = 0;
        req_alu_num_i = 0; req_mem_num_i = 0; alu_rs_full_i = 0; mem_rs_full_i = 0;
        branch_valid_i = 0; branch_mispredict_i = 0; branch_target_i = 0;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; tgt_m[i] = '0; scnt_m[i] = 0; fcnt_m[i] = 0;
        end
        repeat (3) @(posedge clk);

        idle(10);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check("stall_cnt_after_rob_full", {32'd0, scnt0}, 64'd4);
        cycle(0, 1, 0, 2'd1, 0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 2'd2, 0, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 32'h0);

        // Mispredict, wrong-path mispredicts during recovery, then one back in RUN.
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0100);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0200);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0200);
        idle(1);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0300);
        idle(6);

        // Mispredict coinciding with a structural hazard, branch_valid gating.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0400);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(5);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0600);

        // Reset in the middle of recovery, then normal stalling resumes.
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0700);
        idle(1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(3);

        // Drive the 4-bit counters of dut2 into saturation.
        for (int k = 0; k < 40; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h1000 + 32'(k));
            idle(4);
        end
        check("stall_cnt_saturated", {60'd0, scnt2}, 64'd15);
        check("flush_cnt_saturated", {60'd0, fcnt2}, 64'd15);

        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom % 300) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
                  2'($urandom), 2'($urandom), ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 4) == 0, ($urandom % 2) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
